// File: rtl/wb_merge_buffer.sv
// Write-back merge FIFO: queues up to two {reg, data} writes per cycle and drains up to two per cycle
// into a dual-port register file. Also provides a lookup of pending writes for operand bypass.
module wb_merge_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [4:0]               a_reg,
  input  logic [31:0]              a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [4:0]               b_reg,
  input  logic [31:0]              b_data,
  input  logic                     wb_stall,
  output logic                     RegWrite,
  output logic [4:0]               Write_register,
  output logic [4:0]               Write_register2,
  output logic [31:0]              Write_data,
  output logic [31:0]              Write_data2,
  input  logic [4:0]               lk_reg,
  output logic                     lk_hit,
  output logic [31:0]              lk_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0]  rg;
    logic [31:0] dat;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   b_slot;
  logic [CW-1:0]   count_q, count_d;
  logic            a_en, b_en;
  logic [1:0]      drain_n;
  entry_t          head, head2;

  // Ready looks only at the registered occupancy; a same-cycle drain earns no credit.
  assign a_ready = (count_q <= CW'(DEPTH - 1));
  assign b_ready = (count_q <= CW'(DEPTH - 2));

  // Writes to r0 are handshaken but never stored.
  assign a_en   = a_valid && a_ready && (a_reg != 5'd0);
  assign b_en   = b_valid && b_ready && (b_reg != 5'd0);
  assign b_slot = wr_ptr_q + AW'(a_en);

  assign head  = mem_q[rd_ptr_q];
  assign head2 = mem_q[rd_ptr_q + AW'(1)];
  assign count = count_q;

  always_comb begin
    drain_n         = 2'd0;
    RegWrite        = 1'b0;
    Write_register  = 5'd0;
    Write_data      = 32'd0;
    Write_register2 = 5'd0;
    Write_data2     = 32'd0;
    if (!wb_stall && count_q != '0) begin
      RegWrite       = 1'b1;
      Write_register = head.rg;
      Write_data     = head.dat;
      if (count_q == CW'(1)) begin
        drain_n = 2'd1;
      end else begin
        drain_n         = 2'd2;
        Write_register2 = head2.rg;
        Write_data2     = head2.dat;
      end
    end
  end

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_q) && (lk_reg != 5'd0) &&
          (mem_q[rd_ptr_q + AW'(i)].rg == lk_reg)) begin
        lk_hit  = 1'b1;
        lk_data = mem_q[rd_ptr_q + AW'(i)].dat;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(a_en) + AW'(b_en);
    rd_ptr_d = rd_ptr_q + AW'(drain_n);
    count_d  = count_q + CW'(a_en) + CW'(b_en) - CW'(drain_n);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (reset && a_en) mem_q[wr_ptr_q] <= '{rg: a_reg, dat: a_data};
    if (reset && b_en) mem_q[b_slot]   <= '{rg: b_reg, dat: b_data};
  end
endmodule
